// File: rtl/pending_encoder_32x5_pkg.sv
// rtl/pending_encoder_32x5_pkg.sv - shared constants, state encoding and 5x32 decoder
// Contents:
//   WIDTH, IDX_W   request line count and index width
//   state_t        ST_IDLE (nothing offered) / ST_OFFER (IDX offered to consumer)
//   decode_5x32    one-hot of a 5-bit index, used as the pending-bit clear mask
`ifndef PENDING_ENCODER_32X5_PKG_SV
`define PENDING_ENCODER_32X5_PKG_SV
package pending_encoder_32x5_pkg;
   localparam int WIDTH = 32;
   localparam int IDX_W = 5;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_OFFER = 1'b1
   } state_t;

   function automatic logic [WIDTH-1:0] decode_5x32(input logic [IDX_W-1:0] idx);
      logic [WIDTH-1:0] onehot;
      onehot      = '0;
      onehot[idx] = 1'b1;
      return onehot;
   endfunction
endpackage
`endif

// File: rtl/priority_encoder_32x5.sv
// rtl/priority_encoder_32x5.sv - combinational lowest-set-bit encoder
// Ports:
//   vec  in   32  input vector
//   idx  out  5   index of the lowest set bit of vec (0 when vec is zero)
//   any  out  1   1 when any bit of vec is set
module priority_encoder_32x5
   import pending_encoder_32x5_pkg::*;
(
   input  logic [WIDTH-1:0] vec,
   output logic [IDX_W-1:0] idx,
   output logic             any
);

   // Scan from the top down so the last hit, and therefore the winner, is the lowest bit.
   always_comb begin
      idx = '0;
      any = 1'b0;
      for (int i = WIDTH - 1; i >= 0; i--) begin
         if (vec[i]) begin
            idx = i[IDX_W-1:0];
            any = 1'b1;
         end
      end
   end

endmodule

// File: rtl/pending_encoder_32x5.sv
// rtl/pending_encoder_32x5.sv - serialises a multi-hot request set into indices, lowest first
// Ports:
//   CLK      in   1   clock, rising edge
//   RESET    in   1   synchronous reset, active-high
//   LOAD     in   1   OR REQ_IN into the pending set this edge
//   REQ_IN   in   32  request bits, bit n requests index n
//   READY    in   1   consumer accepts IDX when VALID=1
//   VALID    out  1   IDX holds an offered index
//   IDX      out  5   offered index (registered)
//   PENDING  out  32  pending set, excluding the offered index
//   EMPTY    out  1   PENDING==0 and VALID==0
module pending_encoder_32x5
   import pending_encoder_32x5_pkg::*;
(
   input  logic             CLK,
   input  logic             RESET,
   input  logic             LOAD,
   input  logic [WIDTH-1:0] REQ_IN,
   input  logic             READY,
   output logic             VALID,
   output logic [IDX_W-1:0] IDX,
   output logic [WIDTH-1:0] PENDING,
   output logic             EMPTY
);

   state_t           state_q, state_d;
   logic [WIDTH-1:0] pend_q, pend_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic [WIDTH-1:0] eff_set;
   logic [WIDTH-1:0] clr_mask;
   logic [IDX_W-1:0] low_idx;
   logic             any_set;
   logic             take;

   // Requests arriving this cycle are visible to the issue decision in the same cycle.
   assign eff_set = pend_q | (LOAD ? REQ_IN : '0);

   priority_encoder_32x5 u_prio (
      .vec (eff_set),
      .idx (low_idx),
      .any (any_set)
   );

   assign clr_mask = decode_5x32(low_idx);

   always_ff @(posedge CLK) begin
      if (RESET) begin
         state_q <= ST_IDLE;
         pend_q  <= '0;
         idx_q   <= '0;
      end else begin
         state_q <= state_d;
         pend_q  <= pend_d;
         idx_q   <= idx_d;
      end
   end

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      pend_d  = eff_set;
      take    = (state_q == ST_IDLE) || READY;
      if (take) begin
         if (any_set) begin
            idx_d   = low_idx;
            state_d = ST_OFFER;
            pend_d  = eff_set & ~clr_mask;
         end else begin
            // IDX keeps its last value; only VALID drops.
            state_d = ST_IDLE;
            pend_d  = '0;
         end
      end
   end

   assign VALID   = (state_q == ST_OFFER);
   assign IDX     = idx_q;
   assign PENDING = pend_q;
   assign EMPTY   = (pend_q == '0) && !VALID;

endmodule

// File: tb/tb_pending_encoder_32x5.sv
// tb/tb_pending_encoder_32x5.sv - self-checking bench for pending_encoder_32x5
module tb_pending_encoder_32x5;

   logic        CLK = 1'b0;
   logic        RESET = 1'b1;
   logic        LOAD = 1'b0;
   logic [31:0] REQ_IN = '0;
   logic        READY = 1'b0;
   logic        VALID;
   logic [4:0]  IDX;
   logic [31:0] PENDING;
   logic        EMPTY;

   int tests = 0;
   int fails = 0;
   bit chk_en = 1'b0;

   pending_encoder_32x5 dut (
      .CLK     (CLK),
      .RESET   (RESET),
      .LOAD    (LOAD),
      .REQ_IN  (REQ_IN),
      .READY   (READY),
      .VALID   (VALID),
      .IDX     (IDX),
      .PENDING (PENDING),
      .EMPTY   (EMPTY)
   );

   always #5 CLK = ~CLK;

   // Reference: a set of waiting request numbers plus the number currently on offer.
   logic [31:0] m_pend = '0;
   int          m_idx = 0;
   bit          m_valid = 1'b0;

   function automatic int lowest(input logic [31:0] s);
      for (int n = 0; n < 32; n++)
         if (s[n]) return n;
      return -1;
   endfunction

   always @(posedge CLK) begin
      logic [31:0] e;
      int          n;
      if (RESET) begin
         m_pend  = '0;
         m_idx   = 0;
         m_valid = 1'b0;
      end else begin
         e = m_pend | (LOAD ? REQ_IN : 32'h0);
         if (!m_valid || READY) begin
            n = lowest(e);
            if (n >= 0) begin
               m_idx   = n;
               m_valid = 1'b1;
               e[n]    = 1'b0;
               m_pend  = e;
            end else begin
               m_valid = 1'b0;
               m_pend  = '0;
            end
         end else begin
            m_pend = e;
         end
      end
   end

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, got, exp, $time);
      end
   endtask

   // Single compare process: DUT against the model every cycle once reset has been applied.
   always @(negedge CLK) begin
      if (chk_en) begin
         check("cmp_valid",   {31'b0, VALID}, {31'b0, m_valid});
         check("cmp_idx",     {27'b0, IDX},   m_idx);
         check("cmp_pending", PENDING,        m_pend);
         check("cmp_empty",   {31'b0, EMPTY}, {31'b0, (m_pend == 0) && !m_valid});
      end
   end

   task automatic drive(input logic rst, input logic ld, input logic [31:0] req, input logic rdy);
      RESET  = rst;
      LOAD   = ld;
      REQ_IN = req;
      READY  = rdy;
      @(posedge CLK);
      #1;
   endtask

   initial begin
      logic [31:0] r;
      drive(1, 0, 0, 0);
      drive(1, 1, 32'hFFFF_FFFF, 1);
      chk_en = 1'b1;

      // reset state
      check("rst_valid", {31'b0, VALID}, 0);
      check("rst_idx", {27'b0, IDX}, 0);
      check("rst_pending", PENDING, 0);
      check("rst_empty", {31'b0, EMPTY}, 1);

      // 1: empty load
      drive(0, 1, 32'h0, 1);
      check("t1_valid", {31'b0, VALID}, 0);
      check("t1_empty", {31'b0, EMPTY}, 1);
      check("t1_pending", PENDING, 0);

      // 2: 0x80000011, READY held
      drive(0, 1, 32'h8000_0011, 1);
      check("t2_valid0", {31'b0, VALID}, 1);
      check("t2_idx0", {27'b0, IDX}, 0);
      drive(0, 0, 0, 1);
      check("t2_idx4", {27'b0, IDX}, 4);
      drive(0, 0, 0, 1);
      check("t2_idx31", {27'b0, IDX}, 31);
      drive(0, 0, 0, 1);
      check("t2_valid_end", {31'b0, VALID}, 0);
      check("t2_empty_end", {31'b0, EMPTY}, 1);
      check("t2_idx_hold", {27'b0, IDX}, 31);

      // 3: stall then release
      drive(0, 1, 32'h6, 0);
      for (int k = 0; k < 3; k++) begin
         check("t3_idx_stall", {27'b0, IDX}, 1);
         check("t3_valid_stall", {31'b0, VALID}, 1);
         check("t3_pend_stall", PENDING, 32'h4);
         if (k < 2) drive(0, 0, 0, 0);
      end
      drive(0, 0, 0, 1);
      check("t3_idx2", {27'b0, IDX}, 2);
      check("t3_pend_after", PENDING, 0);
      drive(0, 0, 0, 1);
      check("t3_valid_end", {31'b0, VALID}, 0);

      // 4a: lower bit arrives while 2 is offered, no preemption
      drive(0, 1, 32'h4, 0);
      check("t4_idx2", {27'b0, IDX}, 2);
      drive(0, 1, 32'h1, 0);
      check("t4_no_preempt", {27'b0, IDX}, 2);
      check("t4_pend1", PENDING, 32'h1);
      drive(0, 0, 0, 1);
      check("t4_idx0", {27'b0, IDX}, 0);
      drive(0, 0, 0, 1);
      check("t4_drained", {31'b0, VALID}, 0);
      // 4b: re-request of in-flight index while stalled, then accepted
      drive(0, 1, 32'h4, 0);
      drive(0, 1, 32'h4, 0);
      check("t4_rereq_pend", PENDING, 32'h4);
      drive(0, 0, 0, 1);
      check("t4_again_idx", {27'b0, IDX}, 2);
      check("t4_again_valid", {31'b0, VALID}, 1);
      // 4c: re-request at the accepting edge is offered straight away
      drive(0, 1, 32'h4, 1);
      check("t4_same_edge_idx", {27'b0, IDX}, 2);
      check("t4_same_edge_valid", {31'b0, VALID}, 1);
      check("t4_same_edge_pend", PENDING, 0);
      drive(0, 0, 0, 1);
      check("t4_end", {31'b0, VALID}, 0);

      // 5: reset mid-operation
      drive(0, 1, 32'hFFFF_0001, 0);
      check("t5_pre_pend", PENDING, 32'hFFFF_0000);
      drive(1, 1, 32'h1, 1);
      check("t5_valid", {31'b0, VALID}, 0);
      check("t5_idx", {27'b0, IDX}, 0);
      check("t5_pending", PENDING, 0);
      check("t5_empty", {31'b0, EMPTY}, 1);
      for (int k = 0; k < 3; k++) begin
         drive(0, 0, 0, 1);
         check("t5_quiet", {31'b0, VALID}, 0);
      end

      // 6: full set, back-to-back
      drive(0, 1, 32'hFFFF_FFFF, 1);
      for (int k = 0; k < 32; k++) begin
         check("t6_valid", {31'b0, VALID}, 1);
         check("t6_idx", {27'b0, IDX}, k);
         drive(0, 0, 0, 1);
      end
      check("t6_end", {31'b0, EMPTY}, 1);

      // randomized traffic, model-checked each cycle
      for (int c = 0; c < 3000; c++) begin
         case ($urandom_range(0, 2))
            0: r = 32'h1 << $urandom_range(0, 31);
            1: r = $urandom & $urandom & $urandom;
            default: r = $urandom;
         endcase
         drive(($urandom_range(0, 199) == 0), ($urandom_range(0, 3) == 0), r,
               ($urandom_range(0, 2) != 0));
      end
      drive(0, 0, 0, 1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
